// File: rtl/sr_rw_engine.sv
// rtl/sr_rw_engine.sv - multi-channel shift-register write/readback engine
// Shifts N_CH images out on sr_clk, pulses sr_load, streams back captured bits and counts mismatches.
module sr_rw_engine #(
  parameter int WIDTH     = 170,
  parameter int N_CH      = 1,
  parameter int DIV_WIDTH = 6,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                               clk_in,
  input  logic                               rst,
  input  logic [DIV_WIDTH-1:0]               div,
  input  logic                               wr_en,
  input  logic [15:0]                        din,
  input  logic                               start,
  input  logic                               cmp_en,
  output logic                               busy,
  output logic                               done,
  output logic                               sr_clk,
  output logic [N_CH-1:0]                    sr_dout,
  output logic                               sr_load,
  input  logic [N_CH-1:0]                    sr_din,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [31:0]                        rd_data,
  output logic [$clog2(N_CH*WIDTH+1)-1:0]    err_cnt
);
  localparam int NB  = N_CH * WIDTH;
  localparam int WPC = (WIDTH + 15) / 16;
  localparam int RPC = (WIDTH + 31) / 32;
  localparam int CW  = $clog2(NB + 1);
  localparam int CHW = $clog2(N_CH + 1);
  localparam int WWW = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int RWW = (RPC > 1) ? $clog2(RPC) : 1;
  localparam int BW  = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DRAIN} state_t;
  state_t state, state_nxt;

  logic [NB-1:0]        image, prev_img, shreg, cap;
  logic [CHW-1:0]       wr_ch, rd_ch;
  logic [WWW-1:0]       wr_wi;
  logic [RWW-1:0]       rd_wi;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 cmp_q, phase;
  logic [DIV_WIDTH:0]   cnt;
  logic [BW-1:0]        bit_cnt;
  logic [CW-1:0]        mism;
  logic [31:0]          rd_word;

  // Rotating (not zero-filling) leaves the shifted image intact after WIDTH steps.
  function automatic logic [NB-1:0] rot(input logic [NB-1:0] v);
    logic [NB-1:0] r;
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < WIDTH; b++)
        r[c*WIDTH+b] = MSB_FIRST ? v[c*WIDTH + (b+WIDTH-1)%WIDTH] : v[c*WIDTH + (b+1)%WIDTH];
    return r;
  endfunction

  function automatic logic [N_CH-1:0] head(input logic [NB-1:0] v);
    logic [N_CH-1:0] h;
    for (int c = 0; c < N_CH; c++)
      h[c] = MSB_FIRST ? v[c*WIDTH+WIDTH-1] : v[c*WIDTH];
    return h;
  endfunction

  function automatic logic [NB-1:0] cap_push(input logic [NB-1:0] v, input logic [N_CH-1:0] s);
    logic [NB-1:0] r;
    for (int c = 0; c < N_CH; c++)
      for (int b = 0; b < WIDTH; b++) begin
        if (MSB_FIRST) r[c*WIDTH+b] = (b == 0) ? s[c] : v[c*WIDTH + (b+WIDTH-1)%WIDTH];
        else           r[c*WIDTH+b] = (b == WIDTH-1) ? s[c] : v[c*WIDTH + (b+1)%WIDTH];
      end
    return r;
  endfunction

  logic half_end, bit_end, last_bit, load_end, xfer, last_word;
  assign half_end  = (cnt == {1'b0, div_q});
  assign bit_end   = (state == SHIFT) && phase && half_end;
  assign last_bit  = (bit_cnt == BW'(WIDTH-1));
  assign load_end  = (state == LOAD) && (cnt == {div_q, 1'b1});
  assign xfer      = rd_valid && rd_ready;
  assign last_word = (rd_ch == CHW'(N_CH-1)) && (rd_wi == RWW'(RPC-1));
  assign busy      = (state != IDLE);
  assign rd_data   = rd_word;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (bit_end && last_bit) state_nxt = LOAD;
      LOAD:    if (load_end) state_nxt = DRAIN;
      DRAIN:   if (xfer && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mism = '0;
    for (int i = 0; i < NB; i++) mism = mism + CW'(cap[i] ^ prev_img[i]);
  end

  // Word selection is channel-major, LSB word first; bits past WIDTH read as zero.
  always_comb begin
    rd_word = '0;
    for (int c = 0; c < N_CH; c++)
      for (int r = 0; r < RPC; r++)
        for (int b = 0; b < 32; b++)
          if ((32*r + b < WIDTH) && rd_ch == CHW'(c) && rd_wi == RWW'(r))
            rd_word[b] = cap[c*WIDTH + (32*r + b) % WIDTH];
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      image    <= '0;
      prev_img <= '0;
      shreg    <= '0;
      cap      <= '0;
      wr_ch    <= '0;
      wr_wi    <= '0;
      rd_ch    <= '0;
      rd_wi    <= '0;
      div_q    <= '0;
      cmp_q    <= 1'b0;
      cnt      <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      done     <= 1'b0;
      sr_clk   <= 1'b0;
      sr_dout  <= '0;
      sr_load  <= 1'b0;
      rd_valid <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE && wr_en && wr_ch < CHW'(N_CH)) begin
        for (int c = 0; c < N_CH; c++)
          for (int b = 0; b < WIDTH; b++)
            if (wr_ch == CHW'(c) && wr_wi == WWW'(b/16)) image[c*WIDTH+b] <= din[b%16];
        if (wr_wi == WWW'(WPC-1)) begin
          wr_wi <= '0;
          wr_ch <= wr_ch + 1'b1;
        end else begin
          wr_wi <= wr_wi + 1'b1;
        end
      end
      case (state)
        IDLE: if (start) begin
          div_q   <= div;
          cmp_q   <= cmp_en;
          shreg   <= image;
          sr_dout <= head(image);
          cnt     <= '0;
          phase   <= 1'b0;
          bit_cnt <= '0;
          wr_ch   <= '0;
          wr_wi   <= '0;
        end
        SHIFT: if (half_end) begin
          cnt   <= '0;
          phase <= ~phase;
          if (!phase) begin
            sr_clk <= 1'b1;
          end else begin
            sr_clk  <= 1'b0;
            cap     <= cap_push(cap, sr_din);
            shreg   <= rot(shreg);
            bit_cnt <= bit_cnt + 1'b1;
            if (last_bit) begin
              sr_dout <= '0;
              sr_load <= 1'b1;
            end else begin
              sr_dout <= head(rot(shreg));
            end
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        LOAD: if (load_end) begin
          sr_load  <= 1'b0;
          cnt      <= '0;
          prev_img <= shreg;
          rd_ch    <= '0;
          rd_wi    <= '0;
          if (cmp_q) err_cnt <= mism;
        end else begin
          cnt <= cnt + 1'b1;
        end
        DRAIN: if (!rd_valid) begin
          rd_valid <= 1'b1;
        end else if (rd_ready) begin
          if (last_word) begin
            rd_valid <= 1'b0;
            done     <= 1'b1;
          end else if (rd_wi == RWW'(RPC-1)) begin
            rd_wi <= '0;
            rd_ch <= rd_ch + 1'b1;
          end else begin
            rd_wi <= rd_wi + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_rw_engine.sv
// tb/tb_sr_rw_engine.sv - scoreboard bench for sr_rw_engine (WIDTH=20, N_CH=2)
module tb_sr_rw_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, start, cmp_en, rd_ready;
  logic [5:0]  div;
  logic [15:0] din;
  logic        busy, done, sr_clk, sr_load, rd_valid;
  logic [1:0]  sr_dout, sr_din;
  logic [31:0] rd_data;
  logic [5:0]  err_cnt;

  sr_rw_engine #(.WIDTH(20), .N_CH(2), .DIV_WIDTH(6), .MSB_FIRST(1'b1)) dut (
    .clk_in(clk), .rst(rst), .div(div), .wr_en(wr_en), .din(din), .start(start),
    .cmp_en(cmp_en), .busy(busy), .done(done), .sr_clk(sr_clk), .sr_dout(sr_dout),
    .sr_load(sr_load), .sr_din(sr_din), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .err_cnt(err_cnt)
  );

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Chain model: 20-bit memory per channel, output is its MSB, shifts on the falling sr_clk.
  logic        loop_mode = 1'b1, corrupt = 1'b0;
  logic [19:0] mem0 = '0, mem1 = '0, dlog0 = '0, dlog1 = '0;
  logic [1:0]  in_lat = '0;
  int          rise_cnt = 0, rise_base = 0, load_cyc = 0, load_base = 0, done_cnt = 0;
  always @(posedge sr_clk) begin
    rise_cnt++;
    dlog0  = {dlog0[18:0], sr_dout[0]};
    dlog1  = {dlog1[18:0], sr_dout[1]};
    in_lat = sr_dout;
  end
  always @(negedge sr_clk) begin
    mem0 = {mem0[18:0], in_lat[0]};
    mem1 = {mem1[18:0], in_lat[1]};
  end
  assign sr_din = loop_mode ? sr_dout
                            : {mem1[19], mem0[19] ^ (corrupt && (rise_cnt - rise_base == 15))};

  logic [31:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_d = '0;
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(rd_valid), 32'd1);
        chk("hold_data", rd_data, hold_d);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_word_extra: got 0x%0h expected none", rd_data);
        end else begin
          chk("rd_word", rd_data, exp_q.pop_front());
        end
      end
      if (done) done_cnt++;
      if (sr_load) load_cyc++;
      hold_pend = rd_valid && !rd_ready;
      hold_d    = rd_data;
    end
  end

  task automatic wr(input logic [15:0] w);
    @(posedge clk); #1 wr_en = 1'b1; din = w;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic run_txn(input logic [5:0] d, input bit ce, input bit stall, input bit interfere,
                         output int lat);
    int d0, n;
    d0 = done_cnt;
    rise_base = rise_cnt;
    load_base = load_cyc;
    if (stall) rd_ready = 1'b0;
    @(posedge clk); #1 div = d; cmp_en = ce; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; lat = 1;
    while (!rd_valid && lat < 3000) begin
      if (interfere && lat == 20) begin start = 1'b1; wr_en = 1'b1; din = 16'h5555; end
      else if (interfere && lat == 21) begin start = 1'b0; wr_en = 1'b0; end
      @(posedge clk); #1 lat++;
    end
    chk("valid_seen", 32'(rd_valid), 32'd1);
    if (stall) begin
      repeat (10) @(posedge clk);
      #1 rd_ready = 1'b1;
    end
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk); #1 n++;
    end
    chk("done_seen", 32'(done_cnt != d0), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int lat, d0;
    rst = 1'b1; div = '0; wr_en = 1'b0; din = '0; start = 1'b0; cmp_en = 1'b0; rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {26'd0, busy, done, sr_clk, sr_load, rd_valid, 1'b0}, 32'd0);
    chk("reset_dout", 32'(sr_dout), 32'd0);
    chk("reset_rd_data", rd_data, 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);

    // Loopback transaction with latency, load length and MSB-first bit order
    wr(16'hABCD); wr(16'h000E); wr(16'h1234); wr(16'h0005);
    exp_q.push_back(32'h000EABCD); exp_q.push_back(32'h00051234);
    run_txn(6'd1, 1'b0, 1'b0, 1'b0, lat);
    chk("latency_div1", 32'(lat), 32'd86);
    chk("sr_clk_rises", 32'(rise_cnt - rise_base), 32'd20);
    chk("sr_load_cycles", 32'(load_cyc - load_base), 32'd4);
    chk("dout_order_ch0", {12'd0, dlog0}, 32'h000EABCD);
    chk("dout_order_ch1", {12'd0, dlog1}, 32'h00051234);

    // Chain model: readback returns what the previous transaction left in the chips
    loop_mode = 1'b0;
    wr(16'h1357); wr(16'h000F); wr(16'h2468); wr(16'h0009);
    exp_q.push_back(32'h000EABCD); exp_q.push_back(32'h00051234);
    run_txn(6'd1, 1'b1, 1'b0, 1'b0, lat);
    chk("err_cnt_match_a", 32'(err_cnt), 32'd0);
    wr(16'hFFFF); wr(16'h0000); wr(16'h0000); wr(16'h000A);
    exp_q.push_back(32'h000F1357); exp_q.push_back(32'h00092468);
    run_txn(6'd0, 1'b1, 1'b0, 1'b0, lat);
    chk("latency_div0", 32'(lat), 32'd44);
    chk("err_cnt_match_b", 32'(err_cnt), 32'd0);
    // Returned bit 15 of channel 0 flipped (capture bit 5), consumer stalls 10 cycles
    corrupt = 1'b1;
    exp_q.push_back(32'h0000FFDF); exp_q.push_back(32'h000A0000);
    run_txn(6'd1, 1'b1, 1'b1, 1'b0, lat);
    corrupt = 1'b0;
    chk("err_cnt_one_bit", 32'(err_cnt), 32'd1);

    // Writes beyond capacity, start and wr_en while busy are all ignored
    loop_mode = 1'b1;
    wr(16'h0F0F); wr(16'h0003); wr(16'h00FF); wr(16'h0000);
    for (int i = 0; i < 5; i++) wr(16'hFFFF);
    exp_q.push_back(32'h00030F0F); exp_q.push_back(32'h000000FF);
    run_txn(6'd2, 1'b0, 1'b0, 1'b1, lat);
    chk("err_cnt_hold", 32'(err_cnt), 32'd1);
    exp_q.push_back(32'h00030F0F); exp_q.push_back(32'h000000FF);
    run_txn(6'd1, 1'b0, 1'b0, 1'b0, lat);

    // Reset mid-SHIFT aborts without done and clears the image
    @(posedge clk); #1 div = 6'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 chk("busy_mid_shift", 32'(busy), 32'd1);
    rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    chk("abort_ctrl", {27'd0, busy, sr_clk, sr_load, rd_valid, done}, 32'd0);
    chk("abort_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1 chk("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    exp_q.push_back(32'h00000000); exp_q.push_back(32'h00000000);
    run_txn(6'd0, 1'b0, 1'b0, 1'b0, lat);
    wr(16'h5A5A); wr(16'h0001); wr(16'hA5A5); wr(16'h0002);
    exp_q.push_back(32'h00015A5A); exp_q.push_back(32'h0002A5A5);
    run_txn(6'd1, 1'b0, 1'b0, 1'b0, lat);

    repeat (5) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
